// File: rtl/uart_pkg.sv
// Shared UART constants, scheduler state encoding and a constant-safe clog2.
package uart_pkg;

    localparam int BAUD_END_9600 = 5208;
    localparam int FRAME_BITS    = 10;
    localparam int BYTE_W        = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side and transmitter-side signals of the shared uart_tx scheduler.
interface uart_tx_sched_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_trig;
    logic [BYTE_W-1:0]         uart_tx;
    logic                      busy;
    logic [IDX_W-1:0]          grant_id;

    // master: the byte producers; slave: the scheduler serving them
    modport master (
        output req, req_data,
        input  ack, tx_trig, uart_tx, busy, grant_id
    );

    modport slave (
        input  req, req_data,
        output ack, tx_trig, uart_tx, busy, grant_id
    );

endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx; times each frame plus guard gap itself
// because the transmitter exposes no busy flag.
module uart_tx_sched #(
    parameter int NUM_REQ    = 2,
    parameter int BAUD_END   = uart_pkg::BAUD_END_9600,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS,
    parameter int GAP_CYC    = 16
) (
    input logic            sclk,
    input logic            s_rst,
    uart_tx_sched_if.slave bus
);

    import uart_pkg::*;

    localparam int TOTAL = BAUD_END * FRAME_BITS + GAP_CYC;
    localparam int CNT_W = clog2(TOTAL);
    localparam int IDX_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    sched_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                trig_q, trig_d;
    logic [BYTE_W-1:0]   tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    gid_q, gid_d;

    logic [IDX_W-1:0]    winner;
    logic                any_req;
    logic                grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        trig_d  = 1'b0;
        tx_d    = tx_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        grant   = 1'b0;

        case (state_q)
            IDLE: grant = any_req;
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    // slot boundary: chain straight into the next frame if anyone waits
                    if (any_req) begin
                        grant = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ack_d[i] = (winner == IDX_W'(i));
                if (winner == IDX_W'(i)) tx_d = bus.req_data[i*BYTE_W +: BYTE_W];
            end
            trig_d  = 1'b1;
            gid_d   = winner;
            ptr_d   = winner;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            ack_q   <= '0;
            trig_q  <= 1'b0;
            tx_q    <= '0;
            busy_q  <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            trig_q  <= trig_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_trig  = trig_q;
    assign bus.uart_tx  = tx_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = gid_q;

endmodule
